gemm_tile_ctrl: RTL

- Sequences one systolic_array instance (N×N, weight-stationary) through a K-tiled GEMM: C[N×N] = Σ_t A_t·B_t.
- Per tile: fetches N weight rows and N activation columns from on-chip SRAMs, generates the row-skewed activation stream, and writes the N result columns to the output buffer.
- The output buffer performs accumulation when o_wr_acc is set. Sits between the NPU command dispatcher and the GEMM datapath.

---
 rtl/gemm_tile_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/gemm_tile_ctrl.sv
// gemm_tile_ctrl: sequences a weight-stationary NxN systolic array through a K-tiled GEMM,
// fetching weights/activations from SRAM and writing (accumulating) result columns.
module gemm_tile_ctrl #(
    parameter int N       = 16,
    parameter int DW      = 8,
    parameter int AW      = 32,
    parameter int ADDR_W  = 10,
    parameter int KT_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_w_base,
    input  logic [ADDR_W-1:0]      cmd_a_base,
    input  logic [ADDR_W-1:0]      cmd_o_base,
    input  logic [KT_W-1:0]        cmd_k_tiles,
    output logic                   done,
    output logic                   busy,
    output logic                   err,
    output logic                   w_rd_en,
    output logic [ADDR_W-1:0]      w_rd_addr,
    input  logic [N*DW-1:0]        w_rd_data,
    output logic                   a_rd_en,
    output logic [ADDR_W-1:0]      a_rd_addr,
    input  logic [N*DW-1:0]        a_rd_data,
    output logic                   sa_load_weights,
    output logic [$clog2(N)-1:0]   sa_weight_row,
    output logic [N*DW-1:0]        sa_weight_in,
    output logic                   sa_start_compute,
    output logic                   sa_clear_acc,
    output logic [N*DW-1:0]        sa_act,
    output logic                   sa_act_valid,
    output logic [N*AW-1:0]        sa_psum,
    input  logic [N*AW-1:0]        sa_result,
    input  logic                   sa_result_valid,
    output logic                   o_wr_en,
    output logic [ADDR_W-1:0]      o_wr_addr,
    output logic [N*AW-1:0]        o_wr_data,
    output logic                   o_wr_acc
);
    localparam int CW = $clog2((TIMEOUT > 2 * N ? TIMEOUT : 2 * N) + 1);
    localparam int RW = $clog2(N);

    typedef enum logic [2:0] {IDLE, LOAD_W, START, STREAM, WAIT_OUT, DRAIN_OUT, DONE} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt, col;
    logic [ADDR_W-1:0] w_ptr, a_ptr, o_base;
    logic [KT_W-1:0] k_tiles, t;
    logic [N*DW-1:0] act_in, act_sk;
    logic accept, res_ok, last_col, last_tile, to_hit, err_set;

    assign accept    = state == IDLE && cmd_valid;
    assign res_ok    = state == WAIT_OUT || state == DRAIN_OUT;
    assign col       = state == DRAIN_OUT ? cnt : '0;
    assign last_col  = col == CW'(N - 1);
    assign last_tile = t == k_tiles - KT_W'(1);
    assign to_hit    = state == WAIT_OUT && !sa_result_valid && cnt == CW'(TIMEOUT - 1);
    assign err_set   = (sa_result_valid && !res_ok) || to_hit || (state == DRAIN_OUT && !sa_result_valid);
    assign act_in    = (state == STREAM && cnt < CW'(N)) ? a_rd_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = accept ? (cmd_k_tiles == '0 ? DONE : LOAD_W) : IDLE;
            LOAD_W:    state_nx = cnt == CW'(N) ? START : LOAD_W;
            START:     state_nx = STREAM;
            STREAM:    state_nx = cnt == CW'(2 * N - 1) ? WAIT_OUT : STREAM;
            WAIT_OUT, DRAIN_OUT:
                if (!sa_result_valid) state_nx = (state == DRAIN_OUT || to_hit) ? DONE : WAIT_OUT;
                else                  state_nx = !last_col ? DRAIN_OUT : last_tile ? DONE : LOAD_W;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready        = state == IDLE;
        busy             = state != IDLE;
        done             = state == DONE;
        w_rd_en          = state == LOAD_W && cnt < CW'(N);
        w_rd_addr        = w_rd_en ? w_ptr + ADDR_W'(cnt) : '0;
        sa_load_weights  = state == LOAD_W && cnt != '0;
        sa_weight_row    = sa_load_weights ? RW'(cnt - CW'(1)) : '0;
        sa_weight_in     = sa_load_weights ? w_rd_data : '0;
        sa_start_compute = state == START;
        sa_clear_acc     = state == START;
        a_rd_en          = state == START || (state == STREAM && cnt < CW'(N - 1));
        a_rd_addr        = a_rd_en ? a_ptr + (state == START ? '0 : ADDR_W'(cnt) + ADDR_W'(1)) : '0;
        sa_act_valid     = state == STREAM;
        sa_act           = sa_act_valid ? act_sk : '0;
        sa_psum          = '0;
        o_wr_en          = res_ok && sa_result_valid;
        o_wr_addr        = o_wr_en ? o_base + ADDR_W'(col) : '0;
        o_wr_data        = o_wr_en ? sa_result : '0;
        o_wr_acc         = o_wr_en && t != '0;
    end

    // cnt is the per-state cycle index; the first result column is written in WAIT_OUT, so DRAIN_OUT starts at 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            w_ptr   <= '0;
            a_ptr   <= '0;
            o_base  <= '0;
            k_tiles <= '0;
            t       <= '0;
            err     <= 1'b0;
        end else begin
            cnt <= (state_nx == state && state != IDLE) ? cnt + CW'(1) : (state_nx == DRAIN_OUT ? CW'(1) : '0);
            err <= accept ? 1'b0 : err | err_set;
            if (accept) begin
                w_ptr   <= cmd_w_base;
                a_ptr   <= cmd_a_base;
                o_base  <= cmd_o_base;
                k_tiles <= cmd_k_tiles;
                t       <= '0;
            end else if (res_ok && state_nx == LOAD_W) begin
                t     <= t + KT_W'(1);
                w_ptr <= w_ptr + ADDR_W'(N);
                a_ptr <= a_ptr + ADDR_W'(N);
            end
        end
    end

    // row i of the activation stream is delayed i cycles; zeros after the last column flush the lines
    for (genvar i = 0; i < N; i++) begin : g_row
        if (i == 0) begin : g_direct
            assign act_sk[0 +: DW] = act_in[0 +: DW];
        end else begin : g_delay
            logic [DW-1:0] dl [i];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < i; j++) dl[j] <= '0;
                end else begin
                    dl[0] <= act_in[i*DW +: DW];
                    for (int j = 1; j < i; j++) dl[j] <= dl[j-1];
                end
            end
            assign act_sk[i*DW +: DW] = dl[i-1];
        end
    end
endmodule
